instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
//==============================================================================
// instr_loader: streams little-endian bytes into 32-bit instruction RAM words
// and holds the CPU core in reset until the load completes.
// Optional macro LOADER_CHECKSUM_EN adds a trailing 32-bit checksum check.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_loader #(
    parameter int unsigned WORDS = 2048
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        write_o,
    output logic [12:0] addr_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        core_rst_no,
    output logic        err_o
);

    localparam logic [10:0] LAST_WORD = 11'(WORDS - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_CHECK = 3'd4,
        S_ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [10:0] wcnt_q, wcnt_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [12:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        bcnt_d       = bcnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        data_d       = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        byte_ready_o = 1'b0;
        write_o      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        core_rst_no  = 1'b0;
        err_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RECV;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i) begin
                    bcnt_d = bcnt_q + 2'd1;
                    unique case (bcnt_q)
                        2'd0: word_d[7:0]   = byte_i;
                        2'd1: word_d[15:8]  = byte_i;
                        2'd2: word_d[23:16] = byte_i;
                        default: begin
                            // Address and data are latched here so they stay put after the strobe.
                            data_d  = {byte_i, word_q};
                            addr_d  = {wcnt_q, 2'b00};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                write_o = 1'b1;
                busy_o  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = sum_q + data_q;
`endif
                if (wcnt_q == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    wcnt_d  = wcnt_q + 11'd1;
                    state_d = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i) begin
                    bcnt_d = bcnt_q + 2'd1;
                    unique case (bcnt_q)
                        2'd0: word_d[7:0]   = byte_i;
                        2'd1: word_d[15:8]  = byte_i;
                        2'd2: word_d[23:16] = byte_i;
                        default: state_d = ({byte_i, word_q} == sum_q) ? S_DONE : S_ERR;
                    endcase
                end
            end
            S_ERR: begin
                err_o = 1'b1;
            end
`endif
            S_DONE: begin
                done_o      = 1'b1;
                core_rst_no = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
//==============================================================================
// tb_instr_loader: scoreboard bench for instr_loader (WORDS=2 and WORDS=2048).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, start_i, byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o, write_o, busy_o, done_o, core_rst_no, err_o;
    logic [12:0] addr_o;
    logic [31:0] data_o;

    logic        b_start, b_valid;
    logic [7:0]  b_byte;
    logic        b_ready, b_write, b_busy, b_done, b_core_rst_n, b_err;
    logic [12:0] b_addr;
    logic [31:0] b_data;

    instr_loader #(.WORDS(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i),
        .byte_ready_o(byte_ready_o), .write_o(write_o), .addr_o(addr_o),
        .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
        .core_rst_no(core_rst_no), .err_o(err_o)
    );

    instr_loader #(.WORDS(2048)) u_big (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(b_start),
        .byte_valid_i(b_valid), .byte_i(b_byte),
        .byte_ready_o(b_ready), .write_o(b_write), .addr_o(b_addr),
        .data_o(b_data), .busy_o(b_busy), .done_o(b_done),
        .core_rst_no(b_core_rst_n), .err_o(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [44:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Write monitor for the small instance: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (write_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'b0, write_o}, 32'd0);
            end else begin
                logic [44:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {19'b0, addr_o}, {19'b0, e[44:32]});
                chk("wr_data", data_o, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] bword(input int i);
        bword = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    int          b_writes = 0;
    int          b_bad    = 0;
    logic [12:0] b_last_addr = '0;
    always @(negedge clk) begin
        if (b_write === 1'b1) begin
            if (b_addr !== 13'(b_writes * 4) || b_data !== bword(b_writes)) b_bad++;
            b_last_addr = b_addr;
            b_writes++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input bit big, input logic [7:0] b);
        int  n;
        logic rdy;
        n = 0;
        if (big) begin b_valid = 1'b1; b_byte = b; end
        else begin byte_valid_i = 1'b1; byte_i = b; end
        do begin
            @(negedge clk);
            rdy = big ? b_ready : byte_ready_o;
            @(posedge clk);
            n++;
        end while (rdy !== 1'b1 && n < 50);
        if (rdy !== 1'b1) chk("byte_timeout", {31'b0, rdy}, 32'd1);
        #1;
        if (big) b_valid = 1'b0; else byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input bit big, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(big, w[8*k +: 8]);
    endtask

    task automatic pulse_start(input bit big);
        if (big) b_start = 1'b1; else start_i = 1'b1;
        @(posedge clk);
        #1;
        if (big) b_start = 1'b0; else start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, byte_ready_o}, 32'd0);
        chk("rst_write", {31'b0, write_o}, 32'd0);
        chk("rst_busy",  {31'b0, busy_o}, 32'd0);
        chk("rst_done",  {31'b0, done_o}, 32'd0);
        chk("rst_err",   {31'b0, err_o}, 32'd0);
        chk("rst_core",  {31'b0, core_rst_no}, 32'd0);
        chk("rst_addr",  {19'b0, addr_o}, 32'd0);
        chk("rst_data",  data_o, 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    // After the last data byte: optional checksum, then the terminal DONE state.
    task automatic finish_load(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
        send_word(1'b0, sum);
        @(negedge clk);
`else
        @(negedge clk);
        chk("last_write_strobe", {31'b0, write_o}, 32'd1);
        @(negedge clk);
        chk("unused_sum", sum, sum);
        n_checks--; n_pass--;
`endif
        chk("done", {31'b0, done_o}, 32'd1);
        chk("core_released", {31'b0, core_rst_no}, 32'd1);
        chk("no_err", {31'b0, err_o}, 32'd0);
        chk("idle_busy", {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = '0;
        b_start = 1'b0; b_valid = 1'b0; b_byte = '0;

        do_reset();

        // Back-to-back two-word load.
        exp_q.push_back({13'h0000, 32'h12345678});
        exp_q.push_back({13'h0004, 32'hDEADBEEF});
        pulse_start(1'b0);
        chk("busy_recv", {31'b0, busy_o}, 32'd1);
        chk("ready_recv", {31'b0, byte_ready_o}, 32'd1);
        send_word(1'b0, 32'h12345678);
        send_word(1'b0, 32'hDEADBEEF);
        finish_load(32'h12345678 + 32'hDEADBEEF);
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        chk("done_terminal", {31'b0, done_o}, 32'd1);
        chk("done_not_busy", {31'b0, busy_o}, 32'd0);

        // Stall between bytes 1 and 2.
        do_reset();
        exp_q.push_back({13'h0000, 32'h12345678});
        exp_q.push_back({13'h0004, 32'hDEADBEEF});
        pulse_start(1'b0);
        send_byte(1'b0, 8'h78);
        send_byte(1'b0, 8'h56);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", {31'b0, byte_ready_o}, 32'd1);
            @(posedge clk);
            #1;
        end
        send_byte(1'b0, 8'h34);
        send_byte(1'b0, 8'h12);
        send_word(1'b0, 32'hDEADBEEF);
        finish_load(32'h12345678 + 32'hDEADBEEF);

        // Reset after six bytes: only the first word reaches RAM.
        do_reset();
        exp_q.push_back({13'h0000, 32'h12345678});
        pulse_start(1'b0);
        send_word(1'b0, 32'h12345678);
        send_byte(1'b0, 8'hEF);
        send_byte(1'b0, 8'hBE);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_pending", 32'(exp_q.size()), 32'd0);
        exp_q.push_back({13'h0000, 32'h12345678});
        exp_q.push_back({13'h0004, 32'hDEADBEEF});
        pulse_start(1'b0);
        send_word(1'b0, 32'h12345678);
        send_word(1'b0, 32'hDEADBEEF);
        finish_load(32'h12345678 + 32'hDEADBEEF);

        // Valid bytes in IDLE are ignored; start held during RECV has no effect.
        do_reset();
        byte_valid_i = 1'b1; byte_i = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", {31'b0, byte_ready_o}, 32'd0);
            chk("idle_busy_pre", {31'b0, busy_o}, 32'd0);
            @(posedge clk);
        end
        #1 byte_valid_i = 1'b0;
        exp_q.push_back({13'h0000, 32'h04030201});
        exp_q.push_back({13'h0004, 32'h08070605});
        pulse_start(1'b0);
        start_i = 1'b1;
        send_word(1'b0, 32'h04030201);
        send_word(1'b0, 32'h08070605);
        finish_load(32'h04030201 + 32'h08070605);
        start_i = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        exp_q.push_back({13'h0000, 32'h00000001});
        exp_q.push_back({13'h0004, 32'h00000002});
        pulse_start(1'b0);
        send_word(1'b0, 32'h00000001);
        send_word(1'b0, 32'h00000002);
        send_word(1'b0, 32'h00000004);
        @(negedge clk);
        chk("cksum_err", {31'b0, err_o}, 32'd1);
        chk("cksum_err_done", {31'b0, done_o}, 32'd0);
        chk("cksum_err_core", {31'b0, core_rst_no}, 32'd0);
`endif

        // Full 2048-word load on the large instance.
        begin
            logic [31:0] bsum;
            int          n;
            bsum = '0;
            pulse_start(1'b1);
            for (int i = 0; i < 2048; i++) begin
                send_word(1'b1, bword(i));
                bsum = bsum + bword(i);
            end
`ifdef LOADER_CHECKSUM_EN
            send_word(1'b1, bsum);
`endif
            n = 0;
            while (b_done !== 1'b1 && n < 20) begin
                @(posedge clk);
                n++;
            end
            @(negedge clk);
            chk("big_done", {31'b0, b_done}, 32'd1);
            chk("big_writes", 32'(b_writes), 32'd2048);
            chk("big_last_addr", {19'b0, b_last_addr}, 32'h1FFC);
            chk("big_bad_writes", 32'(b_bad), 32'd0);
            chk("big_err", {31'b0, b_err}, 32'd0);
        end

        repeat (2) @(posedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
